// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM states and latency constants for mul_div_unit.
// Optional feature macro used by the unit: MDU_FAST_MULT_EN.
package mdu_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FIX   = 2'd2;

   localparam int MDU_ITER = 32;

endpackage

// File: rtl/md_iter_core.sv
// md_iter_core: one shift-add (multiply) or restoring-subtract (divide) step.
// Divide packs {remainder, quotient} into the 64-bit accumulator.
module md_iter_core (
   input  logic        is_div_i,
   input  logic [63:0] acc_i,
   input  logic [31:0] m_i,
   output logic [63:0] acc_o
);

   logic [32:0] sum;
   logic        ge;
   logic [31:0] sub;

   always_comb begin
      sum = {1'b0, acc_i[63:32]} + {1'b0, m_i};
      // shifted remainder is 33 bits wide; the difference always fits in 32
      ge  = acc_i[63:31] >= {1'b0, m_i};
      sub = acc_i[62:31] - m_i;
      if (is_div_i) begin
         acc_o = ge ? {sub, acc_i[30:0], 1'b1}
                    : {acc_i[62:0], 1'b0};
      end else begin
         acc_o = acc_i[0] ? {sum, acc_i[31:1]}
                          : {1'b0, acc_i[63:32], acc_i[31:1]};
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide owning HI/LO for the MIPS core.
// MDU_FAST_MULT_EN selects a single-cycle multiplier; divide stays iterative.
module mul_div_unit
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   logic [1:0]  state_q, state_d;
   logic        busy_q, busy_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] m_q, m_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        div_q, div_d;
   logic        neg_q, neg_d;
   logic        rneg_q, rneg_d;
   logic        dz_q, dz_d;

   logic        is_mul, is_dv, sgn_op, sa, sb, go_run;
   logic [31:0] mag_a, mag_b;
   logic [63:0] acc_nx, res;

   assign is_mul = (op == MD_MULT) | (op == MD_MULTU);
   assign is_dv  = (op == MD_DIV) | (op == MD_DIVU);
   assign sgn_op = (op == MD_MULT) | (op == MD_DIV);
   assign sa     = sgn_op & A[31];
   assign sb     = sgn_op & B[31];
   assign mag_a  = sa ? (~A + 32'd1) : A;
   assign mag_b  = sb ? (~B + 32'd1) : B;

`ifdef MDU_FAST_MULT_EN
   logic signed [63:0] xa, xb, fprod;
   assign xa    = {{32{sa}}, A};
   assign xb    = {{32{sb}}, B};
   assign fprod = xa * xb;
`endif

   md_iter_core u_core (
      .is_div_i (div_q),
      .acc_i    (acc_q),
      .m_i      (m_q),
      .acc_o    (acc_nx)
   );

   always_comb begin
      if (div_q) begin
         res[63:32] = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
         res[31:0]  = neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
      end else begin
         res = neg_q ? (~acc_q + 64'd1) : acc_q;
      end
   end

   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      acc_d   = acc_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      go_run  = 1'b0;
      if (flush) begin
         state_d = ST_IDLE;
         busy_d  = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  unique case (1'b1)
                     op == MD_MTHI: hi_d = A;
                     op == MD_MTLO: lo_d = A;
                     is_mul: begin
`ifdef MDU_FAST_MULT_EN
                        {hi_d, lo_d} = fprod;
`else
                        go_run = 1'b1;
`endif
                     end
                     is_dv:   go_run = 1'b1;
                     default: ;
                  endcase
               end
               if (go_run) begin
                  state_d = ST_RUN;
                  busy_d  = 1'b1;
                  cnt_d   = 5'd0;
                  div_d   = is_dv;
                  neg_d   = sa ^ sb;
                  rneg_d  = sa;
                  dz_d    = is_dv & (B == 32'd0);
                  // multiplier/dividend sits in the low half of the accumulator
                  acc_d   = is_dv ? {32'd0, mag_a} : {32'd0, mag_b};
                  m_d     = is_dv ? mag_b : mag_a;
               end
            end
            ST_RUN: begin
               acc_d = acc_nx;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'(MDU_ITER - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               if (!dz_q) {hi_d, lo_d} = res;
            end
            default: begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         acc_q   <= 64'd0;
         m_q     <= 32'd0;
         cnt_q   <= 5'd0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         acc_q   <= acc_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized checks of mul_div_unit
// against an arithmetic reference model of HI/LO.
module tb_mul_div_unit;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start, flush;
   logic [2:0]  op;
   logic [31:0] A, B;
   logic        busy;
   logic [31:0] hi, lo;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_hi, exp_lo;

`ifdef MDU_FAST_MULT_EN
   localparam int MUL_LAT = 0;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   mul_div_unit dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .A     (A),
      .B     (B),
      .flush (flush),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   // reference: updates exp_hi/exp_lo from the architectural definition
   task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint q, r;
      logic [63:0] p;
      case (o)
         MD_MULT: begin
            p = 64'(longint'($signed(a)) * longint'($signed(b)));
            {exp_hi, exp_lo} = p;
         end
         MD_MULTU: begin
            p = {32'd0, a} * {32'd0, b};
            {exp_hi, exp_lo} = p;
         end
         MD_DIV: if (b != 0) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            exp_lo = q[31:0];
            exp_hi = r[31:0];
         end
         MD_DIVU: if (b != 0) begin
            exp_lo = a / b;
            exp_hi = a % b;
         end
         MD_MTHI: exp_hi = a;
         MD_MTLO: exp_lo = a;
         default: ;
      endcase
   endtask

   // entered and left #1 after a rising edge
   task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, output int cyc);
      op = o; A = a; B = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (busy && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; flush = 1'b0;
      op = 3'd0; A = 32'd0; B = 32'd0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      total++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         bad++;
         $display("FAIL reset: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
      end
      exp_hi = 32'd0; exp_lo = 32'd0;
   endtask

   task automatic test_multu();
      int cyc;
      run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
      total++;
      if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
         bad++;
         $display("FAIL multu_max: hi=%h lo=%h required fffffffe/00000001", hi, lo);
      end
      total++;
      if (cyc !== MUL_LAT) begin
         bad++;
         $display("FAIL multu_latency: busy cycles=%0d required %0d", cyc, MUL_LAT);
      end
   endtask

   task automatic test_mult();
      int cyc;
      run_op(MD_MULT, 32'hFFFF_FFFD, 32'd5, cyc);
      total++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
         bad++;
         $display("FAIL mult_neg: hi=%h lo=%h required ffffffff/fffffff1", hi, lo);
      end
   endtask

   task automatic test_div();
      int cyc;
      run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
      total++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
         bad++;
         $display("FAIL div_neg: hi=%h lo=%h required ffffffff/fffffffd", hi, lo);
      end
      total++;
      if (cyc !== DIV_LAT) begin
         bad++;
         $display("FAIL div_latency: busy cycles=%0d required %0d", cyc, DIV_LAT);
      end
      run_op(MD_DIVU, 32'd100, 32'd7, cyc);
      total++;
      if (hi !== 32'd2 || lo !== 32'd14) begin
         bad++;
         $display("FAIL divu_100_7: hi=%h lo=%h required 00000002/0000000e", hi, lo);
      end
   endtask

   task automatic test_edge_div();
      int cyc;
      run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
      total++;
      if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
         bad++;
         $display("FAIL div_overflow: hi=%h lo=%h required 00000000/80000000", hi, lo);
      end
      run_op(MD_MTHI, 32'hAA, 32'd0, cyc);
      run_op(MD_MTLO, 32'hBB, 32'd0, cyc);
      run_op(MD_DIVU, 32'd5, 32'd0, cyc);
      total++;
      if (hi !== 32'hAA || lo !== 32'hBB) begin
         bad++;
         $display("FAIL div_by_zero: hi=%h lo=%h required 000000aa/000000bb", hi, lo);
      end
      total++;
      if (cyc !== DIV_LAT) begin
         bad++;
         $display("FAIL div_by_zero_latency: busy cycles=%0d required %0d", cyc, DIV_LAT);
      end
   endtask

   task automatic test_mthi();
      int cyc;
      run_op(MD_MTHI, 32'h1234_5678, 32'd0, cyc);
      total++;
      if (hi !== 32'h1234_5678 || busy !== 1'b0 || cyc !== 0) begin
         bad++;
         $display("FAIL mthi: hi=%h busy=%b cyc=%0d required 12345678/0/0", hi, busy, cyc);
      end
      run_op(MD_MTLO, 32'h0BAD_F00D, 32'd0, cyc);
      total++;
      if (lo !== 32'h0BAD_F00D || hi !== 32'h1234_5678 || cyc !== 0) begin
         bad++;
         $display("FAIL mtlo: hi=%h lo=%h cyc=%0d required 12345678/0badf00d/0", hi, lo, cyc);
      end
   endtask

   task automatic test_flush();
      logic [31:0] h0, l0;
      h0 = hi; l0 = lo;
      op = MD_DIVU; A = 32'd1000; B = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      total++;
      if (busy !== 1'b0 || hi !== h0 || lo !== l0) begin
         bad++;
         $display("FAIL flush_mid: busy=%b hi=%h lo=%h required 0/%h/%h", busy, hi, lo, h0, l0);
      end
      repeat (40) @(posedge clk);
      #1;
      total++;
      if (hi !== h0 || lo !== l0) begin
         bad++;
         $display("FAIL flush_later: hi=%h lo=%h required %h/%h", hi, lo, h0, l0);
      end
   endtask

   task automatic test_start_flush();
      logic [31:0] h0, l0;
      h0 = hi; l0 = lo;
      op = MD_MTHI; A = 32'hDEAD_BEEF; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      op = MD_DIV; A = 32'd9; B = 32'd3;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      total++;
      if (busy !== 1'b0 || hi !== h0 || lo !== l0) begin
         bad++;
         $display("FAIL start_flush: busy=%b hi=%h lo=%h required 0/%h/%h", busy, hi, lo, h0, l0);
      end
   endtask

   task automatic test_ignore_start();
      int cyc;
      op = MD_DIVU; A = 32'd100; B = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1 op = MD_MTHI; A = 32'hCAFE_0000; start = 1'b1;
      @(posedge clk); #1;
      op = MD_DIV; A = 32'hFFFF_0000; B = 32'd9;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 7;
      while (busy && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      total++;
      if (hi !== 32'd2 || lo !== 32'd14 || cyc !== DIV_LAT) begin
         bad++;
         $display("FAIL ignore_start: hi=%h lo=%h cyc=%0d required 00000002/0000000e/%0d",
                  hi, lo, cyc, DIV_LAT);
      end
      exp_hi = hi; exp_lo = lo;
   endtask

   task automatic test_random();
      int cyc, lat;
      logic [2:0]  o;
      logic [31:0] a, b;
      for (int i = 0; i < 24; i++) begin
         o = 3'($urandom_range(0, 5));
         a = $urandom;
         b = $urandom;
         if (i % 6 == 1) b = 32'($urandom_range(0, 9));
         if (i % 6 == 3) a = 32'h8000_0000;
         if (i % 6 == 4) b = 32'hFFFF_FFFF;
         if (o == MD_MTHI || o == MD_MTLO) lat = 0;
         else if (o == MD_MULT || o == MD_MULTU) lat = MUL_LAT;
         else lat = DIV_LAT;
         model_op(o, a, b);
         run_op(o, a, b, cyc);
         total++;
         if (hi !== exp_hi || lo !== exp_lo || cyc !== lat) begin
            bad++;
            $display("FAIL random[%0d] op=%0d a=%h b=%h: hi=%h lo=%h cyc=%0d required %h/%h/%0d",
                     i, o, a, b, hi, lo, cyc, exp_hi, exp_lo, lat);
         end
      end
   endtask

   task automatic test_reset_mid();
      op = MD_DIV; A = 32'd12345; B = 32'd11; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      total++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         bad++;
         $display("FAIL reset_mid: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
      end
   endtask

   initial begin
      test_reset();
      test_multu();
      test_mult();
      test_div();
      test_edge_div();
      test_mthi();
      test_flush();
      test_start_flush();
      test_ignore_start();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
